// File: rtl/multichannel_fir_pkg.sv
// Shared types and width helpers for the multichannel FIR engine.
package multichannel_fir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ACCUM,
        DRAIN,
        DONE
    } fir_state_t;

    // Guard bits let 2^addr_w full-scale products sum without overflow.
    function automatic int acc_width(input int data_w, input int addr_w);
        return 2 * data_w + addr_w;
    endfunction

    function automatic longint sat_max(input int data_w);
        return (longint'(1) <<< (data_w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int data_w);
        return -(longint'(1) <<< (data_w - 1));
    endfunction

endpackage

// File: rtl/fir_mac.sv
// One channel's datapath: registered product, wide accumulator and
// the floor-shift plus saturation back to sample width.
module fir_mac
    import multichannel_fir_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_clear,
    input  logic                         i_prod_en,
    input  logic                         i_acc_en,
    input  logic                         i_load_en,
    input  logic signed [DATA_WIDTH-1:0] i_sample,
    input  logic signed [DATA_WIDTH-1:0] i_coeff,
    output logic signed [DATA_WIDTH-1:0] o_result
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = acc_width(DATA_WIDTH, ADDR_WIDTH);
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(DATA_WIDTH));

    logic signed [PROD_W-1:0]     r_product;
    logic signed [ACC_W-1:0]      r_acc;
    logic signed [DATA_WIDTH-1:0] r_result;
    logic signed [ACC_W-1:0]      w_shifted;
    logic signed [DATA_WIDTH-1:0] w_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_product <= '0;
            r_acc     <= '0;
            r_result  <= '0;
        end else begin
            if (i_prod_en) begin
                r_product <= PROD_W'(i_sample) * PROD_W'(i_coeff);
            end
            if (i_clear) begin
                r_acc <= '0;
            end else if (i_acc_en) begin
                r_acc <= r_acc + ACC_W'(r_product);
            end
            if (i_load_en) begin
                r_result <= w_sat;
            end
        end
    end

    // Arithmetic shift floors toward minus infinity, matching Q1 rescaling.
    always_comb begin
        w_shifted = r_acc >>> (DATA_WIDTH - 1);
        w_sat     = DATA_WIDTH'(w_shifted);
        if (w_shifted > MAX_V) begin
            w_sat = DATA_WIDTH'(MAX_V);
        end else if (w_shifted < MIN_V) begin
            w_sat = DATA_WIDTH'(MIN_V);
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/multichannel_fir.sv
// Sequencer for a shared-kernel FIR over several audio channels; walks the
// tap addresses and steers a three-stage fetch/multiply/accumulate pipeline.
module multichannel_fir
    import multichannel_fir_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7,
    parameter int CHANNELS   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          start_addr,
    input  logic [ADDR_WIDTH-1:0]          last_addr,
    output logic [ADDR_WIDTH-1:0]          audio_addr,
    input  logic [CHANNELS*DATA_WIDTH-1:0] audio_data,
    output logic [ADDR_WIDTH-1:0]          kernel_addr,
    input  logic [DATA_WIDTH-1:0]          kernel_data,
    output logic [CHANNELS*DATA_WIDTH-1:0] result,
    output logic                           busy,
    output logic                           done
);

    fir_state_t r_state;
    fir_state_t w_state_next;

    logic [ADDR_WIDTH-1:0] r_audio_addr;
    logic [ADDR_WIDTH-1:0] r_kernel_addr;
    logic [ADDR_WIDTH-1:0] r_last_idx;
    logic r_data_valid, r_data_last;
    logic r_prod_valid, r_prod_last;
    logic r_acc_last;

    logic w_accept;
    logic w_issuing;
    logic w_issue_last;

    assign w_accept     = (r_state == IDLE) && start;
    assign w_issuing    = (r_state == FETCH) || (r_state == ACCUM);
    assign w_issue_last = w_issuing && (r_kernel_addr == r_last_idx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = FETCH;
            FETCH:   w_state_next = w_issue_last ? DRAIN : ACCUM;
            ACCUM:   if (w_issue_last) w_state_next = DRAIN;
            DRAIN:   if (r_acc_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Valid/last flags trail each issued tap through memory, product and
    // accumulate stages; they empty themselves once issuing stops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_audio_addr  <= '0;
            r_kernel_addr <= '0;
            r_last_idx    <= '0;
            r_data_valid  <= 1'b0;
            r_data_last   <= 1'b0;
            r_prod_valid  <= 1'b0;
            r_prod_last   <= 1'b0;
            r_acc_last    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_audio_addr  <= start_addr;
                r_kernel_addr <= '0;
                r_last_idx    <= last_addr - start_addr;
            end else if (w_issuing && !w_issue_last) begin
                r_audio_addr  <= r_audio_addr + ADDR_WIDTH'(1);
                r_kernel_addr <= r_kernel_addr + ADDR_WIDTH'(1);
            end
            r_data_valid <= w_issuing;
            r_data_last  <= w_issue_last;
            r_prod_valid <= r_data_valid;
            r_prod_last  <= r_data_last;
            r_acc_last   <= r_prod_valid && r_prod_last;
        end
    end

    assign audio_addr  = r_audio_addr;
    assign kernel_addr = r_kernel_addr;
    assign busy        = (r_state == FETCH) || (r_state == ACCUM) || (r_state == DRAIN);
    assign done        = (r_state == DONE);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            fir_mac #(
                .DATA_WIDTH(DATA_WIDTH),
                .ADDR_WIDTH(ADDR_WIDTH)
            ) u_mac (
                .clk      (clk),
                .reset    (reset),
                .i_clear  (w_accept),
                .i_prod_en(r_data_valid),
                .i_acc_en (r_prod_valid),
                .i_load_en(r_acc_last),
                .i_sample (audio_data[gi*DATA_WIDTH +: DATA_WIDTH]),
                .i_coeff  (kernel_data),
                .o_result (result[gi*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

endmodule
